// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter state type
package arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_push_arbiter_first_set.sv
// rtl/rr_push_arbiter_first_set.sv - rotating first-set scan starting at a given index
module rr_first_set #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   mask_i,
    input  logic [IDW-1:0] start_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    logic [IDW-1:0] cand;

    // Walk start, start+1, ... with an explicit wrap so non-power-of-two N works.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int i = 0; i < N; i++) begin
            if (!found_o && mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
            cand = (cand == IDW'(N - 1)) ? '0 : cand + IDW'(1);
        end
    end

endmodule

// File: rtl/rr_push_arbiter.sv
// rtl/rr_push_arbiter.sv - packet-locking round-robin arbiter for a FIFO push port
module rr_push_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 64,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__clear_all,
    input  logic [NUM_REQ-1:0]    i__req_valid,
    input  logic [NUM_REQ-1:0]    i__req_last,
    input  logic [DATA_WIDTH-1:0] i__req_data [NUM_REQ-1:0],
    output logic [NUM_REQ-1:0]    o__req_ready,
    output logic                  o__data_out_valid,
    output logic [DATA_WIDTH-1:0] o__data_out,
    output logic                  o__data_out_last,
    input  logic                  i__data_out_ready,
    output logic [ID_WIDTH-1:0]   o__grant_id,
    output logic                  o__locked
);

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] x);
        return (x == ID_WIDTH'(NUM_REQ - 1)) ? '0 : x + ID_WIDTH'(1);
    endfunction

    arb_state_e          r__state_q, r__state_d;
    logic [ID_WIDTH-1:0] r__owner_q, r__owner_d;
    logic [ID_WIDTH-1:0] r__ptr_q,   r__ptr_d;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] sel;
    logic                scan_found;
    logic                blocked;
    logic                xfer;

    rr_first_set #(
        .N   (NUM_REQ),
        .IDW (ID_WIDTH)
    ) u_scan (
        .mask_i  (i__req_valid),
        .start_i (r__ptr_q),
        .found_o (scan_found),
        .idx_o   (scan_idx)
    );

    assign blocked = reset | i__clear_all;

    // Force index 0 during reset so outputs are defined before state is.
    always_comb begin
        if (reset)
            sel = '0;
        else if (r__state_q == LOCKED)
            sel = r__owner_q;
        else
            sel = scan_found ? scan_idx : r__ptr_q;
    end

    assign o__data_out_valid = i__req_valid[sel] & ~blocked;
    assign o__data_out       = i__req_data[sel];
    assign o__data_out_last  = i__req_last[sel] & ~reset;
    assign o__grant_id       = sel;
    assign o__locked         = (r__state_q == LOCKED) & ~reset;
    assign xfer              = o__data_out_valid & i__data_out_ready;

    always_comb begin
        o__req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++)
            o__req_ready[k] = (ID_WIDTH'(k) == sel) & i__data_out_ready & ~blocked;
    end

    always_comb begin
        r__state_d = r__state_q;
        r__owner_d = r__owner_q;
        r__ptr_d   = r__ptr_q;
        if (blocked) begin
            r__state_d = ARB;
            r__owner_d = '0;
            r__ptr_d   = '0;
        end else if (xfer) begin
            if (r__state_q == ARB) begin
                if (i__req_last[sel]) begin
                    r__ptr_d = wrap_inc(sel);
                end else begin
                    r__state_d = LOCKED;
                    r__owner_d = sel;
                end
            end else if (i__req_last[sel]) begin
                r__state_d = ARB;
                r__ptr_d   = wrap_inc(r__owner_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        r__state_q <= r__state_d;
        r__owner_q <= r__owner_d;
        r__ptr_q   <= r__ptr_d;
    end

endmodule
